// File: rtl/interface_adapter_pkg.sv
// Shared definitions for the versatile interface adapter: register map,
// interrupt flag bit positions and timer state encoding.
package interface_adapter_pkg;

  typedef enum logic [3:0] {
    REG_OR0  = 4'd0,
    REG_DDR0 = 4'd1,
    REG_OR1  = 4'd2,
    REG_DDR1 = 4'd3,
    REG_OR2  = 4'd4,
    REG_DDR2 = 4'd5,
    REG_OR3  = 4'd6,
    REG_DDR3 = 4'd7,
    REG_IFR  = 4'd8,
    REG_IER  = 4'd9,
    REG_T_LO = 4'd10,
    REG_T_HI = 4'd11,
    REG_ACR  = 4'd12,
    REG_PCR  = 4'd13
  } ia_reg_e;

  localparam int IFR_TIMER = 6;
  localparam int IFR_ANY   = 7;

  typedef enum logic {
    TMR_STOPPED = 1'b0,
    TMR_RUNNING = 1'b1
  } timer_state_e;

  // Port p occupies address 2p (OR/IR) and 2p+1 (DDR).
  function automatic logic [3:0] port_reg_addr(input int p, input logic is_ddr);
    return 4'(2 * p) | {3'b000, is_ddr};
  endfunction

endpackage

// File: rtl/ia_input_sync.sv
// Two-flop synchroniser for asynchronous pins. In level mode the output is the
// synchronised value (inverted where polarity is 0); in edge mode it pulses one
// cycle per synchronised rising (polarity 1) or falling (polarity 0) edge.
module ia_input_sync #(
  parameter int WIDTH   = 8,
  parameter bit EDGE_EN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] polarity_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  if (EDGE_EN) begin : g_edge
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) prev_q <= '0;
      else        prev_q <= sync_q;
    end

    assign q_o = (sync_q & ~prev_q & polarity_i) | (~sync_q & prev_q & ~polarity_i);
  end else begin : g_level
    assign q_o = ~(sync_q ^ polarity_i);
  end

endmodule

// File: rtl/versatile_interface_adapter.sv
// CPU-bus I/O adapter: NUM_PORTS 8-bit ports with per-bit direction, edge
// triggered control lines, a down-counting interval timer and a masked IRQ.
module versatile_interface_adapter
  import interface_adapter_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int TIMER_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      chip_en,
  input  logic                      readb_write,
  input  logic [3:0]                register_select,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic [NUM_PORTS-1:0][7:0] port_in,
  output logic [NUM_PORTS-1:0][7:0] port_out,
  output logic [NUM_PORTS-1:0][7:0] port_oe,
  input  logic [NUM_PORTS-1:0]      ctrl_in,
  output logic                      irq_n
);

  localparam int TW = TIMER_WIDTH;

  logic [NUM_PORTS-1:0][7:0] or_q, or_d;
  logic [NUM_PORTS-1:0][7:0] ddr_q, ddr_d;
  logic [6:0]                ifr_q, ifr_d;
  logic [6:0]                ier_q, ier_d;
  logic [7:0]                acr_q, acr_d;
  logic [7:0]                pcr_q, pcr_d;
  logic [TW-1:0]             latch_q, latch_d;
  logic [TW-1:0]             cnt_q, cnt_d;
  timer_state_e              tmr_q, tmr_d;

  logic [NUM_PORTS*8-1:0]    pin_sync;
  logic [NUM_PORTS-1:0]      ctrl_edge;
  logic [NUM_PORTS-1:0][7:0] ir;
  logic [6:0]                ifr_set;
  logic [6:0]                ifr_clr;
  logic [15:0]               cnt_ext;
  logic                      irq_any;
  logic                      wr;
  logic                      rd;

  assign wr      = chip_en & ~readb_write;
  assign rd      = chip_en & readb_write;
  assign cnt_ext = 16'(cnt_q);
  assign irq_any = |(ifr_q & ier_q);
  assign irq_n   = ~irq_any;

  assign port_out = or_q;
  assign port_oe  = ddr_q;

  ia_input_sync #(.WIDTH(NUM_PORTS * 8), .EDGE_EN(1'b0)) u_pin_sync (
    .clk        (clk),
    .reset      (reset),
    .d_i        (port_in),
    .polarity_i ({(NUM_PORTS * 8){1'b1}}),
    .q_o        (pin_sync)
  );

  ia_input_sync #(.WIDTH(NUM_PORTS), .EDGE_EN(1'b1)) u_ctrl_sync (
    .clk        (clk),
    .reset      (reset),
    .d_i        (ctrl_in),
    .polarity_i (pcr_q[NUM_PORTS-1:0]),
    .q_o        (ctrl_edge)
  );

  // Output bits read back the register, input bits read the synchronised pin.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      ir[p] = (or_q[p] & ddr_q[p]) | (pin_sync[p*8 +: 8] & ~ddr_q[p]);
    end
  end

  always_comb begin
    or_d    = or_q;
    ddr_d   = ddr_q;
    ier_d   = ier_q;
    acr_d   = acr_q;
    pcr_d   = pcr_q;
    latch_d = latch_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    ifr_set = '0;
    ifr_clr = '0;

    for (int p = 0; p < NUM_PORTS; p++) begin
      if (wr && register_select == port_reg_addr(p, 1'b0)) or_d[p]  = data_in;
      if (wr && register_select == port_reg_addr(p, 1'b1)) ddr_d[p] = data_in;
      if (rd && register_select == port_reg_addr(p, 1'b0)) ifr_clr[p] = 1'b1;
      ifr_set[p] = ctrl_edge[p];
    end

    if (tmr_q == TMR_RUNNING) begin
      if (cnt_q == '0) begin
        ifr_set[IFR_TIMER] = 1'b1;
        if (acr_q[0]) cnt_d = latch_q;
        else          tmr_d = TMR_STOPPED;
      end else begin
        cnt_d = cnt_q - TW'(1);
      end
    end

    if (wr) begin
      case (register_select)
        REG_IFR:  ifr_clr = ifr_clr | data_in[6:0];
        REG_IER:  ier_d = data_in[7] ? (ier_q | data_in[6:0]) : (ier_q & ~data_in[6:0]);
        REG_T_LO: latch_d[7:0] = data_in;
        REG_T_HI: begin
          latch_d[TW-1:8] = data_in[TW-9:0];
          cnt_d           = {data_in[TW-9:0], latch_q[7:0]};
          tmr_d           = TMR_RUNNING;
        end
        REG_ACR:  acr_d = data_in;
        REG_PCR:  pcr_d = data_in;
        default:  ;
      endcase
    end

    if (rd && register_select == REG_T_LO) ifr_clr[IFR_TIMER] = 1'b1;

    // Hardware sets win over software clears; a T_HI write restarts the
    // timer and discards any underflow that coincides with it.
    ifr_d = (ifr_q & ~ifr_clr) | ifr_set;
    if (wr && register_select == REG_T_HI) ifr_d[IFR_TIMER] = 1'b0;
  end

  always_comb begin
    data_out = '0;
    if (rd) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (register_select == port_reg_addr(p, 1'b0)) data_out = ir[p];
        if (register_select == port_reg_addr(p, 1'b1)) data_out = ddr_q[p];
      end
      case (register_select)
        REG_IFR:  data_out = {irq_any, ifr_q};
        REG_IER:  data_out = {1'b1, ier_q};
        REG_T_LO: data_out = cnt_ext[7:0];
        REG_T_HI: data_out = cnt_ext[15:8];
        REG_ACR:  data_out = acr_q;
        REG_PCR:  data_out = pcr_q;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      or_q    <= '0;
      ddr_q   <= '0;
      ifr_q   <= '0;
      ier_q   <= '0;
      acr_q   <= '0;
      pcr_q   <= '0;
      latch_q <= '0;
      cnt_q   <= '0;
      tmr_q   <= TMR_STOPPED;
    end else begin
      or_q    <= or_d;
      ddr_q   <= ddr_d;
      ifr_q   <= ifr_d;
      ier_q   <= ier_d;
      acr_q   <= acr_d;
      pcr_q   <= pcr_d;
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

endmodule

// File: tb/tb_versatile_interface_adapter.sv
// Self-checking bench for versatile_interface_adapter: randomized bus traffic
// compared against cycle-count arithmetic and bit-level expectations.
module tb_versatile_interface_adapter;

  localparam int NP = 2;
  localparam int TW = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               chip_en = 1'b0;
  logic               readb_write = 1'b1;
  logic [3:0]         register_select = '0;
  logic [7:0]         data_in = '0;
  logic [7:0]         data_out;
  logic [NP-1:0][7:0] port_in = '0;
  logic [NP-1:0][7:0] port_out;
  logic [NP-1:0][7:0] port_oe;
  logic [NP-1:0]      ctrl_in = '1;
  logic               irq_n;

  int checks = 0;
  int failures = 0;

  versatile_interface_adapter #(.NUM_PORTS(NP), .TIMER_WIDTH(TW)) dut (
    .clk             (clk),
    .reset           (reset),
    .chip_en         (chip_en),
    .readb_write     (readb_write),
    .register_select (register_select),
    .data_in         (data_in),
    .data_out        (data_out),
    .port_in         (port_in),
    .port_out        (port_out),
    .port_oe         (port_oe),
    .ctrl_in         (ctrl_in),
    .irq_n           (irq_n)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    chip_en = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    chip_en = 1'b1; readb_write = 1'b0; register_select = a; data_in = d;
    @(negedge clk);
    chip_en = 1'b0; readb_write = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    chip_en = 1'b1; readb_write = 1'b1; register_select = a;
    #1 d = data_out;
    @(negedge clk);
    chip_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b0;
    #1;
    checks++; if (port_out !== '0) begin failures++; $display("FAIL reset_port_out got=%h exp=0", port_out); end
    checks++; if (port_oe !== '0) begin failures++; $display("FAIL reset_port_oe got=%h exp=0", port_oe); end
    checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL reset_irq_n got=%b exp=1", irq_n); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    bus_read(4'd9, d);
    checks++; if (d !== 8'h80) begin failures++; $display("FAIL reset_ier got=%h exp=80", d); end
    bus_read(4'd8, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_ifr got=%h exp=00", d); end
    bus_read(4'd10, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_t_lo got=%h exp=00", d); end
  endtask

  task automatic test_port_io();
    logic [7:0] d, o, dd, pin, exp_ir;
    int p;
    do_reset();
    bus_write(4'd1, 8'h0F);
    bus_write(4'd0, 8'hA5);
    port_in[0] = 8'h3C;
    idle(3);
    checks++; if (port_out[0] !== 8'hA5) begin failures++; $display("FAIL port_out0 got=%h exp=a5", port_out[0]); end
    checks++; if (port_oe[0] !== 8'h0F) begin failures++; $display("FAIL port_oe0 got=%h exp=0f", port_oe[0]); end
    bus_read(4'd0, d);
    checks++; if (d !== 8'h35) begin failures++; $display("FAIL ir0_directed got=%h exp=35", d); end
    for (int k = 0; k < 8; k++) begin
      p   = $urandom_range(0, NP - 1);
      o   = 8'($urandom);
      dd  = 8'($urandom);
      pin = 8'($urandom);
      bus_write(4'(2 * p + 1), dd);
      bus_write(4'(2 * p), o);
      port_in[p] = pin;
      idle(3);
      exp_ir = (o & dd) | (pin & ~dd);
      bus_read(4'(2 * p), d);
      checks++; if (d !== exp_ir) begin failures++; $display("FAIL ir_rand p=%0d got=%h exp=%h", p, d, exp_ir); end
      bus_read(4'(2 * p + 1), d);
      checks++; if (d !== dd) begin failures++; $display("FAIL ddr_read p=%0d got=%h exp=%h", p, d, dd); end
      checks++; if (port_oe[p] !== dd || port_out[p] !== o) begin
        failures++; $display("FAIL port_pins p=%0d oe=%h out=%h exp_oe=%h exp_out=%h", p, port_oe[p], port_out[p], dd, o);
      end
    end
  endtask

  task automatic test_timer_oneshot();
    logic [7:0] d;
    int lat;
    for (int t = 0; t < 3; t++) begin
      lat = (t == 0) ? 3 : $urandom_range(1, 10);
      do_reset();
      bus_write(4'd9, 8'hC0);
      bus_write(4'd12, 8'h00);
      bus_write(4'd10, 8'(lat));
      bus_write(4'd11, 8'h00);
      // flag expected from cycle lat+1 after the T_HI write onwards (sticky)
      for (int i = 1; i <= lat + 6; i++) begin
        @(negedge clk);
        checks++; if (irq_n !== !(i >= lat + 1)) begin
          failures++; $display("FAIL oneshot_irq lat=%0d cyc=%0d got=%b exp=%b", lat, i, irq_n, !(i >= lat + 1));
        end
      end
      bus_read(4'd10, d);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL oneshot_hold lat=%0d got=%h exp=00", lat, d); end
      checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL oneshot_clear got=%b exp=1", irq_n); end
      idle(lat + 4);
      checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL oneshot_once got=%b exp=1", irq_n); end
    end
  endtask

  task automatic test_timer_freerun();
    int lat, cnt_exp;
    bit flag, rd;
    for (int t = 0; t < 3; t++) begin
      lat = (t == 0) ? 2 : (t == 1) ? 0 : $urandom_range(1, 6);
      do_reset();
      bus_write(4'd9, 8'hC0);
      bus_write(4'd12, 8'h01);
      bus_write(4'd10, 8'(lat));
      bus_write(4'd11, 8'h00);
      flag = 1'b0;
      for (int i = 1; i <= 24; i++) begin
        rd = ($urandom_range(0, 2) == 0);
        cnt_exp = lat - ((i - 1) % (lat + 1));
        if (rd) begin
          chip_en = 1'b1; readb_write = 1'b1; register_select = 4'd10;
          #1;
          checks++; if (data_out !== 8'(cnt_exp)) begin
            failures++; $display("FAIL freerun_cnt lat=%0d cyc=%0d got=%h exp=%h", lat, i, data_out, 8'(cnt_exp));
          end
        end
        @(negedge clk);
        chip_en = 1'b0;
        if (i % (lat + 1) == 0) flag = 1'b1;
        else if (rd)            flag = 1'b0;
        checks++; if (irq_n !== !flag) begin
          failures++; $display("FAIL freerun_irq lat=%0d cyc=%0d got=%b exp=%b", lat, i, irq_n, !flag);
        end
      end
    end
  endtask

  task automatic test_ctrl_edge();
    logic [7:0] d, exp_ifr, pcr_m;
    int p;
    bit pol, lvl, hit;
    ctrl_in = '1;
    do_reset();
    bus_write(4'd13, 8'h00);
    bus_write(4'd9, 8'h81);
    idle(3);
    bus_read(4'd8, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL ctrl_idle_ifr got=%h exp=00", d); end
    @(negedge clk);
    ctrl_in[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL ctrl_early got=%b exp=1", irq_n); end
    @(negedge clk);
    checks++; if (irq_n !== 1'b0) begin failures++; $display("FAIL ctrl_latency got=%b exp=0", irq_n); end
    bus_read(4'd8, d);
    checks++; if (d !== 8'h81) begin failures++; $display("FAIL ctrl_ifr got=%h exp=81", d); end
    bus_read(4'd0, d);
    bus_read(4'd8, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL ir_read_clear got=%h exp=00", d); end

    bus_write(4'd9, 8'h8F);
    pcr_m = 8'h00;
    for (int k = 0; k < 10; k++) begin
      p   = $urandom_range(0, NP - 1);
      pol = 1'($urandom);
      pcr_m[p] = pol;
      bus_write(4'd13, pcr_m);
      bus_write(4'd8, 8'h7F);
      lvl = ~ctrl_in[p];
      hit = (lvl == pol);
      ctrl_in[p] = lvl;
      idle(4);
      exp_ifr = hit ? (8'h80 | (8'h01 << p)) : 8'h00;
      bus_read(4'd8, d);
      checks++; if (d !== exp_ifr) begin
        failures++; $display("FAIL ctrl_rand p=%0d pol=%0d lvl=%0d got=%h exp=%h", p, pol, lvl, d, exp_ifr);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] d;
    do_reset();
    bus_write(4'd13, 8'h02);
    ctrl_in = '0;
    idle(4);
    bus_write(4'd8, 8'h7F);
    bus_write(4'd9, 8'h82);
    @(negedge clk);
    ctrl_in[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chip_en = 1'b1; readb_write = 1'b0; register_select = 4'd8; data_in = 8'h02;
    @(negedge clk);
    chip_en = 1'b0; readb_write = 1'b1;
    bus_read(4'd8, d);
    checks++; if (d !== 8'h82) begin failures++; $display("FAIL set_beats_clear got=%h exp=82", d); end
    checks++; if (irq_n !== 1'b0) begin failures++; $display("FAIL set_beats_clear_irq got=%b exp=0", irq_n); end
    bus_write(4'd8, 8'h02);
    bus_read(4'd8, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL ifr_write_clear got=%h exp=00", d); end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] d;
    do_reset();
    bus_write(4'd1, 8'hFF);
    bus_write(4'd0, 8'($urandom) | 8'h01);
    bus_write(4'd9, 8'hC0);
    bus_write(4'd12, 8'h01);
    bus_write(4'd10, 8'h05);
    bus_write(4'd11, 8'h00);
    idle(7);
    checks++; if (port_oe[0] !== 8'hFF || irq_n !== 1'b0) begin
      failures++; $display("FAIL midrun_pre oe=%h irq_n=%b exp_oe=ff exp_irq_n=0", port_oe[0], irq_n);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (port_out !== '0 || port_oe !== '0) begin
      failures++; $display("FAIL midrun_ports out=%h oe=%h exp=0", port_out, port_oe);
    end
    checks++; if (irq_n !== 1'b1 || data_out !== 8'h00) begin
      failures++; $display("FAIL midrun_irq irq_n=%b data_out=%h exp=1/00", irq_n, data_out);
    end
    @(negedge clk);
    reset = 1'b1;
    idle(3);
    bus_read(4'd10, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL midrun_timer_stopped got=%h exp=00", d); end
    idle(8);
    checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL midrun_no_irq got=%b exp=1", irq_n); end
  endtask

  task automatic test_unmapped();
    logic [7:0] d;
    logic [3:0] addrs [6] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd14, 4'd15};
    do_reset();
    foreach (addrs[i]) begin
      bus_write(addrs[i], 8'($urandom) | 8'h01);
      bus_read(addrs[i], d);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL unmapped a=%0d got=%h exp=00", addrs[i], d); end
    end
    checks++; if (port_oe !== '0 || port_out !== '0) begin
      failures++; $display("FAIL unmapped_side_effect oe=%h out=%h exp=0", port_oe, port_out);
    end
    bus_read(4'd8, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL unmapped_ifr got=%h exp=00", d); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_port_io();
    test_timer_oneshot();
    test_timer_freerun();
    test_ctrl_edge();
    test_simultaneous();
    test_reset_midrun();
    test_unmapped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
